// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one combinational activation unit among N neurons.
// Two-stage issue/return pipeline; tagged results are broadcast to all requesters.
module activation_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] z_in,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   act_z,
  input  logic [DW-1:0]   act_a,
  output logic [DW-1:0]   a_out,
  output logic            a_valid,
  output logic [IW-1:0]   a_id,
  output logic            busy
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          iss_v_q;
  logic [DW-1:0] act_z_q;
  logic [IW-1:0] iss_id_q;
  logic [DW-1:0] a_out_q;
  logic          a_valid_q;
  logic [IW-1:0] a_id_q;

  logic          grant;
  logic [IW-1:0] gnt_idx;

  // Rotating priority search: first set req bit at or after ptr, wrapping.
  always_comb begin
    ack     = '0;
    grant   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      int idx_v;
      idx_v = int'(ptr_q) + k;
      if (idx_v >= N) idx_v = idx_v - N;
      if (!grant && req[idx_v]) begin
        grant   = 1'b1;
        gnt_idx = IW'(idx_v);
      end
    end
    if (rst) grant = 1'b0;
    if (grant) ack[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      if (gnt_idx == IW'(N - 1)) ptr_d = '0;
      else                       ptr_d = gnt_idx + IW'(1);
    end
  end

  // Issue stage latches the winner's z; return stage captures the shared unit's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      iss_v_q   <= 1'b0;
      act_z_q   <= '0;
      iss_id_q  <= '0;
      a_out_q   <= '0;
      a_valid_q <= 1'b0;
      a_id_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      iss_v_q   <= grant;
      if (grant) begin
        act_z_q  <= z_in[int'(gnt_idx)*DW +: DW];
        iss_id_q <= gnt_idx;
      end
      a_out_q   <= act_a;
      a_id_q    <= iss_id_q;
      a_valid_q <= iss_v_q;
    end
  end

  assign act_z   = act_z_q;
  assign a_out   = a_out_q;
  assign a_valid = a_valid_q;
  assign a_id    = a_id_q;
  assign busy    = iss_v_q | a_valid_q;

endmodule

// File: tb/tb_activation_arbiter.sv
// Directed bench for activation_arbiter; the activation unit is modelled as identity (act_a = act_z).
module tb_activation_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] z_in;
  logic [N-1:0]    ack;
  logic [DW-1:0]   act_z;
  logic [DW-1:0]   act_a;
  logic [DW-1:0]   a_out;
  logic            a_valid;
  logic [IW-1:0]   a_id;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  activation_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .z_in(z_in), .ack(ack),
    .act_z(act_z), .act_a(act_a), .a_out(a_out), .a_valid(a_valid),
    .a_id(a_id), .busy(busy)
  );

  assign act_a = act_z;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq [4];

  initial begin
    seq[0] = 8'h80; seq[1] = 8'h7F; seq[2] = 8'h00; seq[3] = 8'hF0;
    rst  = 1'b1;
    req  = 4'b1111;
    z_in = 32'h30201000;

    // Reset / idle
    cyc();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_valid", 32'(a_valid), 32'h0);
      chk("rst_aout", 32'(a_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      if (c < 2) cyc();
    end
    rst = 1'b0; req = 4'b0000;
    #1;
    cyc();
    chk("idle_ack", 32'(ack), 32'h0);
    chk("idle_valid", 32'(a_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single request, 2-cycle latency
    req = 4'b0100; z_in = 32'h003C0000;
    #1;
    chk("single_ack", 32'(ack), 32'h4);
    cyc();
    req = 4'b0000;
    #1;
    chk("single_actz", 32'(act_z), 32'h3C);
    chk("single_v_early", 32'(a_valid), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    cyc();
    chk("single_valid", 32'(a_valid), 32'h1);
    chk("single_aout", 32'(a_out), 32'h3C);
    chk("single_aid", 32'(a_id), 32'h2);
    cyc();
    chk("single_pulse_end", 32'(a_valid), 32'h0);

    // Pointer wrap and skip (ptr is 3 after the grant to requester 2)
    req = 4'b1000; z_in = 32'h55000000;
    #1;
    chk("wrap_ack3", 32'(ack), 32'h8);
    cyc();
    req = 4'b0011; z_in = 32'h00002211;
    #1;
    chk("wrap_ack0", 32'(ack), 32'h1);
    cyc();
    req = 4'b0010;
    #1;
    chk("wrap_ack1", 32'(ack), 32'h2);
    cyc();
    req = 4'b0000;
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Round-robin fairness from ptr=0
    z_in = 32'h30201000;
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ack", 32'(ack), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
      if (c >= 2) begin
        chk("rr_valid", 32'(a_valid), 32'h1);
        chk("rr_aid", 32'(a_id), 32'((c - 2) % 4));
        chk("rr_aout", 32'(a_out), 32'h10 * 32'((c - 2) % 4));
      end
      cyc();
    end
    chk("rr_drain", 32'(a_valid), 32'h0);

    // Back-to-back single requester with sign-extreme values
    for (int c = 0; c < 6; c++) begin
      req = (c < 4) ? 4'b0001 : 4'b0000;
      if (c < 4) z_in = {24'h0, seq[c]};
      #1;
      chk("b2b_ack", 32'(ack), (c < 4) ? 32'h1 : 32'h0);
      if (c >= 2) begin
        chk("b2b_valid", 32'(a_valid), 32'h1);
        chk("b2b_aout", 32'(a_out), 32'(seq[c-2]));
        chk("b2b_aid", 32'(a_id), 32'h0);
      end
      cyc();
    end
    chk("b2b_drain", 32'(a_valid), 32'h0);

    // Reset mid-operation (ptr is 1 here)
    z_in = 32'hA4B3C2D1;
    req = 4'b0110;
    #1;
    chk("mid_ack0", 32'(ack), 32'h2);
    cyc();
    req = 4'b0100;
    #1;
    chk("mid_ack1", 32'(ack), 32'h4);
    cyc();
    rst = 1'b1; req = 4'b1000;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_valid", 32'(a_valid), 32'h1);
    chk("mid_rst_aid", 32'(a_id), 32'h1);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(a_valid), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_ack", 32'(ack), 32'h8);
    cyc();
    req = 4'b1111;
    #1;
    chk("post_rst_stale", 32'(a_valid), 32'h0);
    chk("post_rst_wrap", 32'(ack), 32'h1);
    cyc();
    req = 4'b0000;
    #1;
    chk("post_rst_valid3", 32'(a_valid), 32'h1);
    chk("post_rst_aid3", 32'(a_id), 32'h3);
    chk("post_rst_aout3", 32'(a_out), 32'hA4);
    cyc();
    chk("post_rst_valid0", 32'(a_valid), 32'h1);
    chk("post_rst_aout0", 32'(a_out), 32'hD1);
    cyc();
    chk("final_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
